warp_barrier_unit: RTL and testbench
====================================

Name: warp_barrier_unit

Overview:
- Consumer of the warp-control bus; sits between the execute-stage warp-control producer and the warp scheduler.
- Tracks per-barrier arrival of warps issuing barrier instructions and reports which warps are stalled.
- Releases all participants in one registered pulse when the last warp arrives, so the scheduler can re-enable them.

Parameters:
- NUM_WARPS, 4, number of hardware warps; power of two, at least 2.
- NUM_BARRIERS, 4, number of barrier slots; power of two, at least 1.
- NW_BITS, log2(NUM_WARPS), warp id width.
- NB_BITS, log2(NUM_BARRIERS), barrier id width; ports use max(NB_BITS,1).

Ports:
- clk  in  1  clock; all state is rising-edge.
- reset  in  1  asynchronous reset, asserted low; deassertion is synchronous to clk upstream.
- ctl_valid  in  1  warp-control bus valid.
- ctl_wid  in  NW_BITS  issuing warp id.
- bar_valid  in  1  barrier field valid; qualified by ctl_valid.
- bar_id  in  NB_BITS  barrier slot index.
- bar_size_m1  in  NW_BITS  participating warp count minus 1.
- flush  in  1  synchronous clear of all barrier state; no release is generated.
- stalled_mask  out  NUM_WARPS  warps currently waiting at any barrier.
- release_valid  out  1  one-cycle pulse: a barrier completed.
- release_id  out  NB_BITS  completed barrier slot.
- release_mask  out  NUM_WARPS  warps released, including the last arriver.
- err_dup  out  1  sticky: an already-stalled warp arrived at a barrier.
- active_mask  out  NUM_BARRIERS  slots with at least one waiting warp.

Behaviour:
- Reset (asynchronous, low): all per-slot masks and counts cleared; every output is 0.
- State per slot b:
  - arr_mask[b], NUM_WARPS bits.
  - arr_cnt[b], NW_BITS bits; equals popcount(arr_mask[b]).
- Request: ctl_valid && bar_valid. One request per cycle at most. A request without bar_valid is ignored.
- Arrival test: on a request, the arrival is the last if arr_cnt[bar_id] == bar_size_m1.
  - The size is taken from each request; the producer guarantees consistency.
- Non-last arrival: on the next edge, set arr_mask[bar_id][ctl_wid] and increment arr_cnt.
- Last arrival: on the next edge:
  - release_valid = 1.
  - release_id = bar_id.
  - release_mask = arr_mask[bar_id] | onehot(ctl_wid).
  - Clear arr_mask and arr_cnt for that slot.
  - The last warp is never marked stalled.
- bar_size_m1 = 0: immediate release; release_mask = onehot(ctl_wid).
- Duplicate arrival: the warp's bit is already set in any arr_mask.
  - The request is dropped and state is unchanged.
  - err_dup sets on the next edge and holds until reset.
- Release timing:
  - release_valid is 0 on any cycle not following a last arrival.
  - release_id and release_mask are held at their last values when release_valid is 0.
- stalled_mask is the OR of all arr_mask, registered, so it reflects a request one cycle after ctl_valid.
- active_mask[b] = (arr_cnt[b] != 0), registered.
- Latency: exactly 1 cycle from request to every output effect. Throughput is 1 request per clock, with no back-pressure.
- A new request to a slot released on the previous cycle sees a cleared slot.
- flush: on the next edge, clears all masks and counts and stalled_mask; err_dup is kept.
  - flush wins over a same-cycle request, which is dropped.
- Counter wrap cannot occur: arr_cnt max is NUM_WARPS-1, because the arrival reaching bar_size_m1 releases the slot.

Test Plan:
- Reset low mid-operation with slot 1 holding warps {0,2} → all outputs 0 immediately (asynchronous). After release of reset, a request from warp 0 stalls only warp 0.
- Barrier 1, size_m1 = 2: warps 0, 2, 3 arrive on consecutive cycles.
  - After warps 0 and 2, stalled_mask = 0101.
  - Cycle after warp 3: release_valid = 1, release_id = 1, release_mask = 1101, stalled_mask = 0000, active_mask = 0000.
- size_m1 = 0, warp 3 at barrier 0 → next cycle release_mask = 1000, stalled_mask never set.
- Warps 1 and 2 interleaved on barriers 0 and 2, each with size_m1 = 1, then warps 0 and 3 complete them.
  - Independent releases: masks 0011 (id 0) and 1100 (id 2).
  - active_mask tracks each slot.
- Warp 1 stalled on barrier 0 issues again to barrier 3 → err_dup = 1, state unchanged, no release.
- Warps 0 and 1 stalled on barrier 2, then flush together with a request from warp 2 → next cycle stalled_mask = 0, no release_valid. A new arrival restarts the count from 0.

Source files
------------

// File: rtl/warp_barrier_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// warp_barrier_unit_if : warp-control request bus and barrier status/release bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface warp_barrier_unit_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NW_BITS = $clog2(NUM_WARPS);
  localparam int NB_BITS = $clog2(NUM_BARRIERS);
  localparam int NB_W    = (NB_BITS > 0) ? NB_BITS : 1;

  logic                    ctl_valid;
  logic [NW_BITS-1:0]      ctl_wid;
  logic                    bar_valid;
  logic [NB_W-1:0]         bar_id;
  logic [NW_BITS-1:0]      bar_size_m1;
  logic                    flush;

  logic [NUM_WARPS-1:0]    stalled_mask;
  logic                    release_valid;
  logic [NB_W-1:0]         release_id;
  logic [NUM_WARPS-1:0]    release_mask;
  logic                    err_dup;
  logic [NUM_BARRIERS-1:0] active_mask;

  modport master (
    output ctl_valid, ctl_wid, bar_valid, bar_id, bar_size_m1, flush,
    input  stalled_mask, release_valid, release_id, release_mask, err_dup, active_mask
  );

  modport slave (
    input  ctl_valid, ctl_wid, bar_valid, bar_id, bar_size_m1, flush,
    output stalled_mask, release_valid, release_id, release_mask, err_dup, active_mask
  );
endinterface
`default_nettype wire

// File: rtl/warp_barrier_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// warp_barrier_unit : per-slot barrier arrival tracking with single-pulse release
// Rev 1.0
// ----------------------------------------------------------------------------
module warp_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  warp_barrier_unit_if.slave    bus
);
  localparam int NW_BITS = $clog2(NUM_WARPS);
  localparam int NB_BITS = $clog2(NUM_BARRIERS);
  localparam int NB_W    = (NB_BITS > 0) ? NB_BITS : 1;
  localparam logic [NW_BITS-1:0] C_CNT_ONE = NW_BITS'(1);

  logic [NUM_WARPS-1:0]    arr_mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    arr_mask_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]      arr_cnt_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]      arr_cnt_d  [NUM_BARRIERS];

  logic [NUM_WARPS-1:0]    stalled_mask_q,  stalled_mask_d;
  logic                    release_valid_q, release_valid_d;
  logic [NB_W-1:0]         release_id_q,    release_id_d;
  logic [NUM_WARPS-1:0]    release_mask_q,  release_mask_d;
  logic                    err_dup_q,       err_dup_d;
  logic [NUM_BARRIERS-1:0] active_mask_q,   active_mask_d;

  logic [NUM_WARPS-1:0]    w_busy;
  logic [NUM_WARPS-1:0]    w_sel_mask;
  logic [NW_BITS-1:0]      w_sel_cnt;
  logic [NUM_WARPS-1:0]    w_onehot;
  logic                    w_req;
  logic                    w_dup;
  logic                    w_acc;
  logic                    w_last;

  // Slot lookup is a compare-mux so a 1-slot build never indexes out of range.
  always_comb begin
    w_busy     = '0;
    w_sel_mask = '0;
    w_sel_cnt  = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      w_busy = w_busy | arr_mask_q[b];
      if (NB_W'(b) == bus.bar_id) begin
        w_sel_mask = arr_mask_q[b];
        w_sel_cnt  = arr_cnt_q[b];
      end
    end
    w_onehot = NUM_WARPS'(1) << bus.ctl_wid;
    w_req    = bus.ctl_valid & bus.bar_valid & ~bus.flush;
    w_dup    = w_req & w_busy[bus.ctl_wid];
    w_acc    = w_req & ~w_dup;
    w_last   = (w_sel_cnt == bus.bar_size_m1);
  end

  always_comb begin
    arr_mask_d      = arr_mask_q;
    arr_cnt_d       = arr_cnt_q;
    release_valid_d = 1'b0;
    release_id_d    = release_id_q;
    release_mask_d  = release_mask_q;
    err_dup_d       = err_dup_q | w_dup;
    stalled_mask_d  = '0;
    active_mask_d   = '0;

    if (bus.flush) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        arr_mask_d[b] = '0;
        arr_cnt_d[b]  = '0;
      end
    end else if (w_acc) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        if (NB_W'(b) == bus.bar_id) begin
          if (w_last) begin
            arr_mask_d[b] = '0;
            arr_cnt_d[b]  = '0;
          end else begin
            arr_mask_d[b] = arr_mask_q[b] | w_onehot;
            arr_cnt_d[b]  = arr_cnt_q[b] + C_CNT_ONE;
          end
        end
      end
      if (w_last) begin
        release_valid_d = 1'b1;
        release_id_d    = bus.bar_id;
        release_mask_d  = w_sel_mask | w_onehot;
      end
    end

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalled_mask_d   = stalled_mask_d | arr_mask_d[b];
      active_mask_d[b] = (arr_cnt_d[b] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_mask_q      <= '{default: '0};
      arr_cnt_q       <= '{default: '0};
      stalled_mask_q  <= '0;
      release_valid_q <= 1'b0;
      release_id_q    <= '0;
      release_mask_q  <= '0;
      err_dup_q       <= 1'b0;
      active_mask_q   <= '0;
    end else begin
      arr_mask_q      <= arr_mask_d;
      arr_cnt_q       <= arr_cnt_d;
      stalled_mask_q  <= stalled_mask_d;
      release_valid_q <= release_valid_d;
      release_id_q    <= release_id_d;
      release_mask_q  <= release_mask_d;
      err_dup_q       <= err_dup_d;
      active_mask_q   <= active_mask_d;
    end
  end

  assign bus.stalled_mask  = stalled_mask_q;
  assign bus.release_valid = release_valid_q;
  assign bus.release_id    = release_id_q;
  assign bus.release_mask  = release_mask_q;
  assign bus.err_dup       = err_dup_q;
  assign bus.active_mask   = active_mask_q;
endmodule
`default_nettype wire

// File: tb/tb_warp_barrier_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_warp_barrier_unit : vector table with expected-output scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_warp_barrier_unit;
  logic clk;
  logic reset;

  warp_barrier_unit_if #(.NUM_WARPS(4), .NUM_BARRIERS(4)) bus ();

  warp_barrier_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [1:0] wid;
    logic       bv;
    logic [1:0] bid;
    logic [1:0] sz;
    logic       fl;
    logic [3:0] e_stall;
    logic       e_rv;
    logic [1:0] e_rid;
    logic [3:0] e_rmask;
    logic       e_err;
    logic [3:0] e_act;
  } vec_t;

  vec_t vecs [20];
  vec_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic cv, logic [1:0] wid, logic bv, logic [1:0] bid,
                              logic [1:0] sz, logic fl, logic [3:0] st, logic rv,
                              logic [1:0] rid, logic [3:0] rm, logic er, logic [3:0] ac);
    vec_t v;
    v.cv = cv; v.wid = wid; v.bv = bv; v.bid = bid; v.sz = sz; v.fl = fl;
    v.e_stall = st; v.e_rv = rv; v.e_rid = rid; v.e_rmask = rm; v.e_err = er; v.e_act = ac;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ctl_valid   = v.cv;
    bus.ctl_wid     = v.wid;
    bus.bar_valid   = v.bv;
    bus.bar_id      = v.bid;
    bus.bar_size_m1 = v.sz;
    bus.flush       = v.fl;
  endtask

  task automatic check(input string name, input vec_t e);
    checks++;
    if (bus.stalled_mask !== e.e_stall || bus.release_valid !== e.e_rv ||
        bus.release_id !== e.e_rid || bus.release_mask !== e.e_rmask ||
        bus.err_dup !== e.e_err || bus.active_mask !== e.e_act) begin
      errors++;
      $display("FAIL %s: got stall=%b rv=%b rid=%0d rmask=%b err=%b act=%b want stall=%b rv=%b rid=%0d rmask=%b err=%b act=%b",
               name, bus.stalled_mask, bus.release_valid, bus.release_id, bus.release_mask,
               bus.err_dup, bus.active_mask, e.e_stall, e.e_rv, e.e_rid, e.e_rmask,
               e.e_err, e.e_act);
    end
  endtask

  // One request per cycle: drive at negedge, expectation queued, compared 1 ns after the edge.
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000);
    drive(idle);
    reset = 1'b0;
    #12;
    check("reset_state", idle);
    @(negedge clk);
    reset = 1'b1;

    //            cv wid bv bid sz fl  stall   rv rid rmask   err act
    vecs[0]  = mk(1, 0, 1, 1, 2, 0, 4'b0001, 0, 0, 4'b0000, 0, 4'b0010);
    vecs[1]  = mk(1, 2, 1, 1, 2, 0, 4'b0101, 0, 0, 4'b0000, 0, 4'b0010);
    vecs[2]  = mk(1, 3, 1, 1, 2, 0, 4'b0000, 1, 1, 4'b1101, 0, 4'b0000);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 4'b1101, 0, 4'b0000);
    vecs[4]  = mk(1, 3, 1, 0, 0, 0, 4'b0000, 1, 0, 4'b1000, 0, 4'b0000);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000);
    vecs[6]  = mk(1, 1, 0, 2, 0, 0, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000);
    vecs[7]  = mk(1, 1, 1, 0, 1, 0, 4'b0010, 0, 0, 4'b1000, 0, 4'b0001);
    vecs[8]  = mk(1, 2, 1, 2, 1, 0, 4'b0110, 0, 0, 4'b1000, 0, 4'b0101);
    vecs[9]  = mk(1, 0, 1, 0, 1, 0, 4'b0100, 1, 0, 4'b0011, 0, 4'b0100);
    vecs[10] = mk(1, 3, 1, 2, 1, 0, 4'b0000, 1, 2, 4'b1100, 0, 4'b0000);
    vecs[11] = mk(1, 1, 1, 0, 1, 0, 4'b0010, 0, 2, 4'b1100, 0, 4'b0001);
    vecs[12] = mk(1, 1, 1, 3, 0, 0, 4'b0010, 0, 2, 4'b1100, 1, 4'b0001);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 4'b0010, 0, 2, 4'b1100, 1, 4'b0001);
    vecs[14] = mk(1, 2, 1, 0, 1, 0, 4'b0000, 1, 0, 4'b0110, 1, 4'b0000);
    vecs[15] = mk(1, 0, 1, 2, 2, 0, 4'b0001, 0, 0, 4'b0110, 1, 4'b0100);
    vecs[16] = mk(1, 1, 1, 2, 2, 0, 4'b0011, 0, 0, 4'b0110, 1, 4'b0100);
    vecs[17] = mk(1, 2, 1, 2, 2, 1, 4'b0000, 0, 0, 4'b0110, 1, 4'b0000);
    vecs[18] = mk(1, 2, 1, 2, 1, 0, 4'b0100, 0, 0, 4'b0110, 1, 4'b0100);
    vecs[19] = mk(1, 3, 1, 2, 1, 0, 4'b0000, 1, 2, 4'b1100, 1, 4'b0000);

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-operation with slot 1 holding warps {0,2}.
    apply("pre_rst_w0", mk(1, 0, 1, 1, 3, 0, 4'b0001, 0, 2, 4'b1100, 1, 4'b0010));
    apply("pre_rst_w2", mk(1, 2, 1, 1, 3, 0, 4'b0101, 0, 2, 4'b1100, 1, 4'b0010));
    @(negedge clk);
    drive(idle);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", idle);
    @(negedge clk);
    reset = 1'b1;
    apply("post_rst_w0", mk(1, 0, 1, 3, 1, 0, 4'b0001, 0, 0, 4'b0000, 0, 4'b1000));
    apply("post_rst_idle", mk(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 4'b0000, 0, 4'b1000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
